// File: rtl/mc_cfg_pkg.sv
// Shared types and constants for the macrocell configuration loader.
// Holds the loader state encoding and the per-macrocell fuse field layout.
package mc_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        PARITY = 2'd2,
        COMMIT = 2'd3
    } state_e;

    localparam int BITS_PER_MC = 5;

    localparam int FLD_PT1  = 0;
    localparam int FLD_PT2  = 1;
    localparam int FLD_XA   = 2;
    localparam int FLD_XB   = 3;
    localparam int FLD_XINV = 4;

endpackage

// File: rtl/mc_cfg_shadow.sv
// Shadow register holding a fuse image while it is being loaded.
// Ports: clk/rst_n, clr (wipe image), we/idx/d (single-bit write), q (image).
module mc_cfg_shadow
    import mc_cfg_pkg::*;
#(
    parameter int NUM_MC = 16,
    localparam int W     = NUM_MC * BITS_PER_MC,
    localparam int IW    = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          we,
    input  logic [IW-1:0] idx,
    input  logic          d,
    output logic [W-1:0]  q
);

    logic [W-1:0] shadow_d;
    logic [W-1:0] shadow_q;

    always_comb begin
        shadow_d = shadow_q;
        if (clr) begin
            shadow_d = '0;
        end else if (we) begin
            shadow_d[idx] = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign q = shadow_q;

endmodule

// File: rtl/mc_cfg_loader.sv
// Serial fuse loader: shifts in NUM_MC*5 routing bits plus an even-parity bit
// and commits all macrocell selects at once. Ports: start/abort control,
// cfg_bit/cfg_valid/cfg_ready stream, busy/done/err status, five select buses.
module mc_cfg_loader
    import mc_cfg_pkg::*;
#(
    parameter int NUM_MC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              cfg_bit,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [NUM_MC-1:0] pt1_mux,
    output logic [NUM_MC-1:0] pt2_mux,
    output logic [NUM_MC-1:0] xor_a_mux,
    output logic [NUM_MC-1:0] xor_b_mux,
    output logic [NUM_MC-1:0] xor_inv_mux
);

    localparam int W  = NUM_MC * BITS_PER_MC;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_e        state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic          par_d, par_q;
    logic          err_d, err_q;
    logic          done_d, done_q;
    logic [W-1:0]  active_d, active_q;

    logic          sh_clr;
    logic          sh_we;
    logic [W-1:0]  sh_q;
    logic          accept;

    assign cfg_ready = (state_q == LOAD) || (state_q == PARITY);
    assign busy      = (state_q != IDLE);
    assign accept    = cfg_valid && cfg_ready;
    assign done      = done_q;
    assign err       = err_q;

    mc_cfg_shadow #(
        .NUM_MC (NUM_MC)
    ) u_shadow (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sh_clr),
        .we    (sh_we),
        .idx   (cnt_q),
        .d     (cfg_bit),
        .q     (sh_q)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        err_d    = err_q;
        done_d   = 1'b0;
        active_d = active_q;
        sh_clr   = 1'b0;
        sh_we    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // start together with abort is treated as no request
                if (start && !abort) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                    err_d   = 1'b0;
                    sh_clr  = 1'b1;
                end
            end
            LOAD: begin
                if (accept) begin
                    sh_we = 1'b1;
                    par_d = par_q ^ cfg_bit;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = PARITY;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            PARITY: begin
                if (accept) begin
                    par_d = par_q ^ cfg_bit;
                    if (par_d) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                state_d  = IDLE;
                active_d = sh_q;
                done_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over everything except reset; err is left as it was.
        if (abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            cnt_d    = '0;
            par_d    = 1'b0;
            err_d    = err_q;
            done_d   = 1'b0;
            active_d = active_q;
            sh_we    = 1'b0;
            sh_clr   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            par_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
            err_q    <= err_d;
            done_q   <= done_d;
            active_q <= active_d;
        end
    end

    // Fan the flat image out to per-field select buses.
    always_comb begin
        pt1_mux     = '0;
        pt2_mux     = '0;
        xor_a_mux   = '0;
        xor_b_mux   = '0;
        xor_inv_mux = '0;
        for (int i = 0; i < NUM_MC; i++) begin
            pt1_mux[i]     = active_q[i*BITS_PER_MC + FLD_PT1];
            pt2_mux[i]     = active_q[i*BITS_PER_MC + FLD_PT2];
            xor_a_mux[i]   = active_q[i*BITS_PER_MC + FLD_XA];
            xor_b_mux[i]   = active_q[i*BITS_PER_MC + FLD_XB];
            xor_inv_mux[i] = active_q[i*BITS_PER_MC + FLD_XINV];
        end
    end

endmodule

// File: tb/tb_mc_cfg_loader.sv
// Directed and randomized bench for mc_cfg_loader with NUM_MC=2.
// Reference keeps the last committed fuse image as per-field bit arrays.
module tb_mc_cfg_loader;

    localparam int N = 2;
    localparam int W = N * 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic         cfg_bit;
    logic         cfg_valid;
    logic         cfg_ready;
    logic         busy;
    logic         done;
    logic         err;
    logic [N-1:0] pt1_mux;
    logic [N-1:0] pt2_mux;
    logic [N-1:0] xor_a_mux;
    logic [N-1:0] xor_b_mux;
    logic [N-1:0] xor_inv_mux;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] m_sel [5];

    mc_cfg_loader #(
        .NUM_MC (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .cfg_bit     (cfg_bit),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .pt1_mux     (pt1_mux),
        .pt2_mux     (pt2_mux),
        .xor_a_mux   (xor_a_mux),
        .xor_b_mux   (xor_b_mux),
        .xor_inv_mux (xor_inv_mux)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_sel(input string tag);
        chk({tag, "_pt1"},  32'(pt1_mux),     32'(m_sel[0]));
        chk({tag, "_pt2"},  32'(pt2_mux),     32'(m_sel[1]));
        chk({tag, "_xa"},   32'(xor_a_mux),   32'(m_sel[2]));
        chk({tag, "_xb"},   32'(xor_b_mux),   32'(m_sel[3]));
        chk({tag, "_xinv"}, 32'(xor_inv_mux), 32'(m_sel[4]));
    endtask

    // Stream bit j belongs to macrocell j/5, field j%5.
    task automatic model_commit(input logic [W-1:0] v);
        for (int j = 0; j < W; j++) begin
            m_sel[j % 5][j / 5] = v[j];
        end
    endtask

    task automatic do_load(input string tag, input logic [W-1:0] v,
                           input logic p, input int gap_at,
                           input int gap_len, input int start_at);
        int   ones;
        logic good;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
        chk({tag, "_errclr"}, 32'(err), 32'd0);
        for (int j = 0; j <= W; j++) begin
            if (j == gap_at) begin
                cfg_valid = 1'b0;
                repeat (gap_len) tick();
                chk({tag, "_gapready"}, 32'(cfg_ready), 32'd1);
            end
            cfg_valid = 1'b1;
            cfg_bit   = (j == W) ? p : v[j];
            start     = (j == start_at);
            tick();
        end
        cfg_valid = 1'b0;
        start     = 1'b0;
        ones = $countones(v) + int'(p);
        good = (ones % 2) == 0;
        if (good) begin
            chk({tag, "_cbusy"}, 32'(busy), 32'd1);
            chk({tag, "_cdone"}, 32'(done), 32'd0);
            check_sel({tag, "_hold"});
            tick();
            model_commit(v);
            chk({tag, "_done"}, 32'(done), 32'd1);
            chk({tag, "_busy"}, 32'(busy), 32'd0);
            chk({tag, "_err"}, 32'(err), 32'd0);
            check_sel({tag, "_new"});
            tick();
            chk({tag, "_done1"}, 32'(done), 32'd0);
        end else begin
            chk({tag, "_berr"}, 32'(err), 32'd1);
            chk({tag, "_bbusy"}, 32'(busy), 32'd0);
            chk({tag, "_bdone"}, 32'(done), 32'd0);
            check_sel({tag, "_bkeep"});
            tick();
            chk({tag, "_bdone1"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] s1;
        logic         p;
        int           ga;
        int           gl;

        s1 = 10'b1001001101;
        for (int f = 0; f < 5; f++) m_sel[f] = '0;

        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_bit   = 1'b0;
        cfg_valid = 1'b0;
        tick();
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        check_sel("rst");
        rst_n = 1'b1;
        tick();

        do_load("ld1", s1, 1'b1, -1, 0, -1);
        chk("ld1_k_pt1",  32'(pt1_mux),     32'd1);
        chk("ld1_k_pt2",  32'(pt2_mux),     32'd2);
        chk("ld1_k_xa",   32'(xor_a_mux),   32'd1);
        chk("ld1_k_xb",   32'(xor_b_mux),   32'd1);
        chk("ld1_k_xinv", 32'(xor_inv_mux), 32'd2);

        do_load("bad", s1, 1'b0, -1, 0, -1);
        do_load("ld2", ~s1, 1'b1, -1, 0, -1);

        do_load("stall", s1, 1'b1, 5, 3, -1);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 6; j++) begin
            cfg_valid = 1'b1;
            cfg_bit   = ~s1[j];
            tick();
        end
        cfg_valid = 1'b0;
        abort     = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy",  32'(busy), 32'd0);
        chk("abort_ready", 32'(cfg_ready), 32'd0);
        chk("abort_done",  32'(done), 32'd0);
        check_sel("abort");
        tick();
        chk("abort_done1", 32'(done), 32'd0);
        do_load("post_abort", ~s1, 1'b1, -1, 0, -1);

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);

        do_load("midstart", s1, 1'b1, -1, 0, 4);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            cfg_valid = 1'b1;
            cfg_bit   = 1'b1;
            tick();
        end
        cfg_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int f = 0; f < 5; f++) m_sel[f] = '0;
        chk("arst_ready", 32'(cfg_ready), 32'd0);
        chk("arst_busy",  32'(busy), 32'd0);
        chk("arst_done",  32'(done), 32'd0);
        chk("arst_err",   32'(err), 32'd0);
        check_sel("arst");
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_idle", 32'(busy), 32'd0);
        do_load("post_rst", s1, 1'b1, -1, 0, -1);

        for (int r = 0; r < 25; r++) begin
            v  = W'($urandom);
            p  = 1'($urandom);
            ga = ($urandom % 3 == 0) ? int'($urandom_range(0, W)) : -1;
            gl = int'($urandom_range(1, 4));
            do_load("rnd", v, p, ga, gl, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
